// File: rtl/yarp_alu_issue.sv
// Operand issue stage for yarp_execute: owns the RV32I register file, registers operands/op_sel,
// and writes back the one-cycle-late ALU result. Optional macro YARP_ISSUE_FWD_EN enables S2 forwarding.
module yarp_alu_issue #(
    parameter logic [31:0] REG_INIT = 32'h0,
    parameter int          ALU_LAT  = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        instr_valid_i,
    output logic        instr_ready_o,
    input  logic [4:0]  rs1_i,
    input  logic [4:0]  rs2_i,
    input  logic [4:0]  rd_i,
    input  logic [31:0] imm_i,
    input  logic        use_imm_i,
    input  logic [3:0]  op_i,
    input  logic        flush_i,
    output logic [31:0] opr_a_o,
    output logic [31:0] opr_b_o,
    output logic [3:0]  op_sel_o,
    input  logic [31:0] alu_res_i,
    output logic        wb_valid_o,
    output logic [4:0]  wb_rd_o,
    output logic [31:0] wb_data_o
);

    generate
        if (ALU_LAT != 1) begin : g_lat_check
            $error("yarp_alu_issue: only ALU_LAT == 1 is supported");
        end
    endgenerate

    // Handshake: an instruction transfers on a rising edge where instr_valid_i and
    // instr_ready_o are both high; while ready is low the decoder holds its inputs stable.

    logic [31:0] r_regs [1:31];

    logic        r_s1_valid;
    logic [4:0]  r_s1_rd;
    logic [31:0] r_opr_a;
    logic [31:0] r_opr_b;
    logic [3:0]  r_op_sel;

    logic        r_s2_valid;
    logic [4:0]  r_s2_rd;

    logic        w_haz_s1;
    logic        w_haz_s2;
    logic        w_accept;
    logic        w_wr_en;
    logic [31:0] w_rs1_val;
    logic [31:0] w_rs2_val;
    logic [31:0] w_opr_b;

    // Operand A resolution: x0, then in-flight S2 result, then the array.
    always_comb begin
        w_rs1_val = '0;
        if (rs1_i == 5'd0) begin
            w_rs1_val = '0;
        end
`ifdef YARP_ISSUE_FWD_EN
        else if (r_s2_valid && (r_s2_rd == rs1_i)) begin
            w_rs1_val = alu_res_i;
        end
`endif
        else begin
            w_rs1_val = r_regs[rs1_i];
        end
    end

    always_comb begin
        w_rs2_val = '0;
        if (rs2_i == 5'd0) begin
            w_rs2_val = '0;
        end
`ifdef YARP_ISSUE_FWD_EN
        else if (r_s2_valid && (r_s2_rd == rs2_i)) begin
            w_rs2_val = alu_res_i;
        end
`endif
        else begin
            w_rs2_val = r_regs[rs2_i];
        end
    end

    assign w_opr_b = use_imm_i ? imm_i : w_rs2_val;

    // S1 result is not available until S2, so a dependent read must wait one cycle.
    assign w_haz_s1 = r_s1_valid && (r_s1_rd != 5'd0) &&
                      ((r_s1_rd == rs1_i) || (!use_imm_i && (r_s1_rd == rs2_i)));

`ifdef YARP_ISSUE_FWD_EN
    assign w_haz_s2 = 1'b0;
`else
    assign w_haz_s2 = r_s2_valid && (r_s2_rd != 5'd0) &&
                      ((r_s2_rd == rs1_i) || (!use_imm_i && (r_s2_rd == rs2_i)));
`endif

    assign instr_ready_o = !flush_i && !w_haz_s1 && !w_haz_s2;
    assign w_accept      = instr_valid_i && instr_ready_o;
    assign w_wr_en       = r_s2_valid && !flush_i && (r_s2_rd != 5'd0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_s1_valid <= 1'b0;
            r_s1_rd    <= '0;
            r_opr_a    <= '0;
            r_opr_b    <= '0;
            r_op_sel   <= '0;
            r_s2_valid <= 1'b0;
            r_s2_rd    <= '0;
        end else begin
            r_s1_valid <= w_accept;
            if (w_accept) begin
                r_s1_rd  <= rd_i;
                r_opr_a  <= w_rs1_val;
                r_opr_b  <= w_opr_b;
                r_op_sel <= op_i;
            end
            r_s2_valid <= r_s1_valid && !flush_i;
            r_s2_rd    <= r_s1_rd;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 1; i < 32; i++) begin
                r_regs[i] <= REG_INIT;
            end
        end else if (w_wr_en) begin
            r_regs[r_s2_rd] <= alu_res_i;
        end
    end

    assign opr_a_o    = r_opr_a;
    assign opr_b_o    = r_opr_b;
    assign op_sel_o   = r_op_sel;
    // Flush suppresses a writeback that is already on the bus this cycle.
    assign wb_valid_o = r_s2_valid && !flush_i;
    assign wb_rd_o    = r_s2_rd;
    assign wb_data_o  = alu_res_i;

endmodule

// File: tb/tb_yarp_alu_issue.sv
// Bench for yarp_alu_issue: directed scenarios plus random instruction stream checked
// against an in-order architectural model; a small stand-in plays the execute stage.
module tb_yarp_alu_issue;
    localparam logic [31:0] INIT = 32'd5;
`ifdef YARP_ISSUE_FWD_EN
    localparam int WIN = 1;
`else
    localparam int WIN = 2;
`endif

    logic        clk;
    logic        reset_n;
    logic        instr_valid_i;
    logic        instr_ready_o;
    logic [4:0]  rs1_i;
    logic [4:0]  rs2_i;
    logic [4:0]  rd_i;
    logic [31:0] imm_i;
    logic        use_imm_i;
    logic [3:0]  op_i;
    logic        flush_i;
    logic [31:0] opr_a_o;
    logic [31:0] opr_b_o;
    logic [3:0]  op_sel_o;
    logic [31:0] alu_res_i;
    logic        wb_valid_o;
    logic [4:0]  wb_rd_o;
    logic [31:0] wb_data_o;

    yarp_alu_issue #(.REG_INIT(INIT), .ALU_LAT(1)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .instr_valid_i(instr_valid_i),
        .instr_ready_o(instr_ready_o),
        .rs1_i        (rs1_i),
        .rs2_i        (rs2_i),
        .rd_i         (rd_i),
        .imm_i        (imm_i),
        .use_imm_i    (use_imm_i),
        .op_i         (op_i),
        .flush_i      (flush_i),
        .opr_a_o      (opr_a_o),
        .opr_b_o      (opr_b_o),
        .op_sel_o     (op_sel_o),
        .alu_res_i    (alu_res_i),
        .wb_valid_o   (wb_valid_o),
        .wb_rd_o      (wb_rd_o),
        .wb_data_o    (wb_data_o)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] alu_f(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
        case (op)
            4'd1:    return a - b;
            4'd2:    return a << b[4:0];
            4'd3:    return a >> b[4:0];
            4'd4:    return a | b;
            4'd5:    return a & b;
            4'd6:    return a ^ b;
            default: return a + b;
        endcase
    endfunction

    // execute stage: registered result one cycle after operands
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) alu_res_i <= '0;
        else          alu_res_i <= alu_f(opr_a_o, opr_b_o, op_sel_o);
    end

    int total;
    int bad;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // architectural model and scoreboard
    logic [31:0] mrf  [32];
    logic [31:0] snap [32];
    logic [36:0] exp_q [$];
    int          due_q [$];
    int          prod_cyc [$];
    logic [4:0]  prod_rd  [$];
    int          cyc;
    logic        pend_opr;
    logic [31:0] pend_a;
    logic [31:0] pend_b;
    logic [3:0]  pend_op;

    task automatic model_reset();
        for (int i = 0; i < 32; i++) mrf[i] = (i == 0) ? 32'd0 : INIT;
        exp_q.delete();
        due_q.delete();
        prod_cyc.delete();
        prod_rd.delete();
        pend_opr = 1'b0;
    endtask

    // A producer accepted at edge p blocks a reader at edge c while c - p <= WIN.
    function automatic logic hazard(input logic [4:0] rs1, input logic [4:0] rs2, input logic ui);
        logic h;
        h = 1'b0;
        for (int i = 0; i < prod_cyc.size(); i++) begin
            if ((cyc + 1 - prod_cyc[i] <= WIN) && (prod_rd[i] != 5'd0) &&
                ((prod_rd[i] == rs1) || (!ui && (prod_rd[i] == rs2))))
                h = 1'b1;
        end
        return h;
    endfunction

    task automatic check_outputs();
        logic [36:0] e;
        if (pend_opr) begin
            check("opr_a", opr_a_o, pend_a);
            check("opr_b", opr_b_o, pend_b);
            check("op_sel", 32'(op_sel_o), 32'(pend_op));
        end
        if (due_q.size() > 0 && due_q[0] == cyc) begin
            e = exp_q.pop_front();
            void'(due_q.pop_front());
            check("wb_valid", 32'(wb_valid_o), 32'd1);
            check("wb_rd", 32'(wb_rd_o), 32'(e[36:32]));
            check("wb_data", wb_data_o, e[31:0]);
        end else begin
            check("wb_idle", 32'(wb_valid_o), 32'd0);
        end
    endtask

    // driver: one clock cycle, entered and left just after a falling edge
    task automatic do_cycle(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                            input logic [4:0] rd, input logic [31:0] imm, input logic ui,
                            input logic [3:0] op, input logic fl, output logic acc);
        logic [31:0] a, b, r;
        instr_valid_i = v;
        rs1_i = rs1;
        rs2_i = rs2;
        rd_i = rd;
        imm_i = imm;
        use_imm_i = ui;
        op_i = op;
        flush_i = fl;
        #1;
        check("ready", 32'(instr_ready_o), 32'(!fl && !hazard(rs1, rs2, ui)));
        if (fl) check("wb_flush", 32'(wb_valid_o), 32'd0);
        acc = v && instr_ready_o;
        if (acc) begin
            a = (rs1 == 5'd0) ? 32'd0 : mrf[rs1];
            b = ui ? imm : ((rs2 == 5'd0) ? 32'd0 : mrf[rs2]);
            r = alu_f(a, b, op);
            if (rd != 5'd0) mrf[rd] = r;
            exp_q.push_back({rd, r});
            due_q.push_back(cyc + 2);
            prod_cyc.push_back(cyc + 1);
            prod_rd.push_back(rd);
            pend_opr = 1'b1;
            pend_a = a;
            pend_b = b;
            pend_op = op;
        end else begin
            pend_opr = 1'b0;
        end
        if (fl) begin
            exp_q.delete();
            due_q.delete();
            prod_cyc.delete();
            prod_rd.delete();
        end
        @(posedge clk);
        cyc++;
        while (prod_cyc.size() > 0 && cyc - prod_cyc[0] >= WIN) begin
            void'(prod_cyc.pop_front());
            void'(prod_rd.pop_front());
        end
        @(negedge clk);
        check_outputs();
    endtask

    task automatic issue(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                         input logic [31:0] imm, input logic ui, input logic [3:0] op,
                         output int stalls);
        logic acc;
        acc = 1'b0;
        stalls = 0;
        for (int k = 0; k < 6 && !acc; k++) begin
            do_cycle(1'b1, rs1, rs2, rd, imm, ui, op, 1'b0, acc);
            if (!acc) stalls++;
        end
        check("accept_timeout", 32'(acc), 32'd1);
    endtask

    task automatic idle(input int n);
        logic acc;
        for (int k = 0; k < n; k++)
            do_cycle(1'b0, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                     $urandom, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 7)), 1'b0, acc);
    endtask

    task automatic flush_cycle();
        logic acc;
        do_cycle(1'b0, 5'd0, 5'd0, 5'd0, 32'd0, 1'b0, 4'd0, 1'b1, acc);
    endtask

    initial begin
        int st;
        total = 0;
        bad = 0;
        cyc = 0;
        reset_n = 1'b0;
        instr_valid_i = 1'b0;
        rs1_i = '0;
        rs2_i = '0;
        rd_i = '0;
        imm_i = '0;
        use_imm_i = 1'b0;
        op_i = '0;
        flush_i = 1'b0;
        model_reset();
        #12;
        check("rst_opr_a", opr_a_o, 32'd0);
        check("rst_opr_b", opr_b_o, 32'd0);
        check("rst_op_sel", 32'(op_sel_o), 32'd0);
        check("rst_wb_valid", 32'(wb_valid_o), 32'd0);
        check("rst_wb_rd", 32'(wb_rd_o), 32'd0);
        check("rst_ready", 32'(instr_ready_o), 32'd1);
        @(negedge clk);
        reset_n = 1'b1;

        // ADD x3 = x1 + x2, then read x3
        issue(5'd1, 5'd2, 5'd3, 32'd0, 1'b0, 4'd0, st);
        idle(2);
        issue(5'd3, 5'd0, 5'd7, 32'd0, 1'b0, 4'd0, st);
        idle(3);

        // ADDI x1 = x0 + 7 then ADD x2 = x1 + x1
        issue(5'd0, 5'd0, 5'd1, 32'd7, 1'b1, 4'd0, st);
        issue(5'd1, 5'd1, 5'd2, 32'd0, 1'b0, 4'd0, st);
        check("raw_stalls", 32'(st), 32'(WIN));
        idle(3);

        // write x0 then read x0
        issue(5'd0, 5'd0, 5'd0, 32'd9, 1'b1, 4'd0, st);
        issue(5'd0, 5'd0, 5'd8, 32'd0, 1'b0, 4'd0, st);
        check("x0_nostall", 32'(st), 32'd0);
        idle(3);

        // immediate op: stall on rs1 only
        issue(5'd0, 5'd0, 5'd6, 32'd1, 1'b1, 4'd0, st);
        issue(5'd6, 5'd0, 5'd5, 32'hFFFF_FFFF, 1'b1, 4'd0, st);
        check("imm_rs1_stall", 32'(st), 32'(WIN));
        idle(3);
        issue(5'd0, 5'd0, 5'd6, 32'd2, 1'b1, 4'd0, st);
        issue(5'd2, 5'd6, 5'd5, 32'd3, 1'b1, 4'd0, st);
        check("imm_rs2_nostall", 32'(st), 32'd0);
        idle(3);

        // flush with the op in S1
        snap = mrf;
        issue(5'd0, 5'd0, 5'd4, 32'd3, 1'b1, 4'd0, st);
        flush_cycle();
        mrf = snap;
        idle(2);
        issue(5'd4, 5'd0, 5'd10, 32'd0, 1'b0, 4'd0, st);
        idle(3);

        // flush with one op in S2 and one in S1
        snap = mrf;
        issue(5'd0, 5'd0, 5'd4, 32'd3, 1'b1, 4'd0, st);
        issue(5'd0, 5'd0, 5'd9, 32'd1, 1'b1, 4'd0, st);
        flush_cycle();
        mrf = snap;
        idle(2);
        issue(5'd4, 5'd9, 5'd11, 32'd0, 1'b0, 4'd0, st);
        idle(3);

        // asynchronous reset with two ops in flight
        issue(5'd0, 5'd0, 5'd12, 32'd4, 1'b1, 4'd0, st);
        issue(5'd0, 5'd0, 5'd13, 32'd5, 1'b1, 4'd0, st);
        #2;
        reset_n = 1'b0;
        #1;
        check("mid_rst_opr_a", opr_a_o, 32'd0);
        check("mid_rst_opr_b", opr_b_o, 32'd0);
        check("mid_rst_op_sel", 32'(op_sel_o), 32'd0);
        check("mid_rst_wb_valid", 32'(wb_valid_o), 32'd0);
        check("mid_rst_wb_rd", 32'(wb_rd_o), 32'd0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        idle(3);
        issue(5'd12, 5'd13, 5'd14, 32'd0, 1'b0, 4'd0, st);
        idle(3);

        // random instruction stream
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                idle(1);
            end else begin
                issue(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                      $urandom, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 7)), st);
            end
        end
        idle(4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1_000_000;
        bad++;
        $display("FAIL watchdog got=timeout exp=finish");
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/yarp_alu_issue.md
Name: yarp_alu_issue

Overview:
- Operand-side counterpart of yarp_execute. Holds the 32x32 RV32I integer register file and accepts decoded ALU instructions over a valid/ready handshake.
- Drives registered operands and op_sel into the execute stage, then captures the one-cycle-late registered ALU result.
- Writes that result back into the register file, with hazard stalling and result forwarding.

Parameters:
- REG_INIT, 32'h0, value loaded into x1..x31 on reset.
- ALU_LAT, 1, cycles between operands driven and alu_res_i valid. Only 1 is supported; any other value must trip an elaboration-time check.

Ports:
- clk  in  1  core clock
- reset_n  in  1  asynchronous active-low reset
- instr_valid_i  in  1  decoded instruction present
- instr_ready_o  out  1  instruction accepted when valid&ready at posedge
- rs1_i  in  5  source register A index
- rs2_i  in  5  source register B index
- rd_i  in  5  destination register index
- imm_i  in  32  immediate value
- use_imm_i  in  1  1: operand B = imm_i, rs2 ignored for hazards
- op_i  in  4  ALU op encoding (yarp_pkg OP_*)
- flush_i  in  1  kill all in-flight operations
- opr_a_o  out  32  to yarp_execute opr_a_i
- opr_b_o  out  32  to yarp_execute opr_b_i
- op_sel_o  out  4  to yarp_execute op_sel_i
- alu_res_i  in  32  from yarp_execute alu_res_o
- wb_valid_o  out  1  writeback occurring this cycle
- wb_rd_o  out  5  writeback destination
- wb_data_o  out  32  writeback data (= alu_res_i)

Behaviour:
- Reset: all registers are asynchronously cleared.
  - x1..x31 = REG_INIT; s1_valid = s2_valid = 0.
  - opr_a_o = opr_b_o = 0; op_sel_o = 0; wb_valid_o = 0; wb_rd_o = 0.
- Pipeline stages:
  - Cycle T, accept: operands are resolved combinationally and registered into S1 at the edge ending T.
  - Cycle T+1, S1: opr_a_o/opr_b_o/op_sel_o are driven from the S1 registers; yarp_execute captures them.
  - Cycle T+2, S2: alu_res_i is valid; wb_valid_o = s2_valid, wb_rd_o = s2_rd, wb_data_o = alu_res_i.
  - The register file is written at the edge ending T+2 if s2_valid and s2_rd != 0.
- Throughput: one instruction per cycle when there are no hazards.
- When no instruction is accepted, S1 is loaded with a bubble: valid 0, operands hold their previous values, op_sel_o holds.
- Operand resolution, in priority order:
  - index 0 reads 32'h0;
  - else if S2 is valid and its rd matches, read alu_res_i (forward);
  - else read the array.
- Operand B = imm_i when use_imm_i = 1.
- Hazard stall: instr_ready_o = 0 when any of the following holds:
  - s1_valid, s1_rd != 0, and s1_rd equals rs1_i, or equals rs2_i with use_imm_i = 0;
  - flush_i = 1.
- When stalled, S1 becomes a bubble and the decoder must hold its inputs stable.
- x0: writes to it are dropped from the array, but wb_valid_o still asserts with wb_rd_o = 0.
- Flush:
  - flush_i at an edge clears s1_valid and s2_valid, and no instruction is accepted that edge.
  - A writeback whose S2 is valid in the flush cycle is suppressed: wb_valid_o is forced to 0 combinationally while flush_i = 1.
- Same-cycle write and read of one register: handled by forwarding from S2, never by the array's old value.
- Reset mid-operation: in-flight operations are discarded and no writeback follows reset deassertion.

Optional Feature:
- Macro: YARP_ISSUE_FWD_EN.
- Defined: S2→operand forwarding is enabled as described above.
- Undefined:
  - no forwarding path exists;
  - the hazard stall additionally covers a match against s2_rd (s2_valid, s2_rd != 0);
  - a dependent instruction therefore accepts two cycles after its producer.

Test Plan:
- Reset then ADD x3 = x1 + x2 with REG_INIT = 5 → opr_a = opr_b = 5 in T+1; wb_valid_o = 1, wb_rd_o = 3, wb_data_o = 10 in T+2; x3 then reads 10.
- Back-to-back ADDI x1 = x0 + 7, then ADD x2 = x1 + x1 → one stall cycle. With FWD_EN: second op accepted at T+2 with opr_a = opr_b = 7, x2 = 14. Without FWD_EN: two stall cycles.
- Write x0 (ADDI x0 = x0 + 9), then read x0 → wb_valid_o = 1, wb_rd_o = 0, subsequent opr_a = 0.
- ADDI x4 = x0 + 3 issued, flush_i pulsed in T+1 → no wb_valid_o in T+2; x4 remains REG_INIT.
- Immediate op SUB-style ADDI x5 = x6 + imm 0xFFFFFFFF with x6 in flight in S1 and use_imm_i = 1 → stall on rs1 only. rs2 field = 6 alone, with use_imm_i = 1 and rs1 not matching, produces no stall.
- reset_n asserted asynchronously mid-stream with 2 ops in flight → outputs are 0 immediately; no writeback after release.
